fifo_sync_ctrl: RTL

- Parametrised single-clock FIFO; successor to the basic 8x8 buffer.
- Adds selectable show-ahead (first-word-fall-through) read mode, almost-full/almost-empty thresholds, a fill-level output, a synchronous flush, and sticky overflow/underflow error flags.
- Sits between producer and consumer blocks in the same clock domain. Drives dataOut directly; no tri-state output.

---
 rtl/fifo_sync_ctrl_if.sv | 30 +++
 rtl/fifo_sync_ctrl.sv | 95 +++++++++
 2 files changed

// File: rtl/fifo_sync_ctrl_if.sv
// Bus between a producer/consumer pair and fifo_sync_ctrl: requests, data and status.
// master drives requests and write data; slave (the FIFO) drives read data and status.
interface fifo_sync_ctrl_if #(
  parameter int DWIDTH = 8,
  parameter int AWIDTH = 3
);
  logic              en;
  logic              clr;
  logic              wr;
  logic              rd;
  logic [DWIDTH-1:0] dataIn;
  logic [DWIDTH-1:0] dataOut;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [AWIDTH:0]   count;
  logic              overflow;
  logic              underflow;

  modport master (
    output en, clr, wr, rd, dataIn,
    input  dataOut, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  en, clr, wr, rd, dataIn,
    output dataOut, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/fifo_sync_ctrl.sv
// Single-clock FIFO, standard (1-cycle registered read) or show-ahead; status decoded from count.
// Backpressure: a write to a full FIFO is dropped and sets overflow unless paired with a read.
module fifo_sync_ctrl #(
  parameter int DWIDTH     = 8,
  parameter int AWIDTH     = 3,
  parameter int FWFT       = 0,
  parameter int AFULL_LVL  = (2**AWIDTH) - 2,
  parameter int AEMPTY_LVL = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  fifo_sync_ctrl_if.slave bus
);
  localparam int DEPTH = 2**AWIDTH;
  localparam logic [AWIDTH:0] DEPTH_C  = (AWIDTH+1)'(DEPTH);
  localparam logic [AWIDTH:0] AFULL_C  = (AWIDTH+1)'(AFULL_LVL);
  localparam logic [AWIDTH:0] AEMPTY_C = (AWIDTH+1)'(AEMPTY_LVL);

  logic [DWIDTH-1:0] mem [DEPTH];
  logic [AWIDTH-1:0] wr_ptr;
  logic [AWIDTH-1:0] rd_ptr;
  logic [AWIDTH:0]   count_q;
  logic              ovf_q;
  logic              udf_q;

  logic full_w;
  logic empty_w;
  logic live;
  logic wr_acc;
  logic rd_acc;
  logic wr_rej;
  logic rd_rej;

  assign full_w  = (count_q == DEPTH_C);
  assign empty_w = (count_q == '0);

  // A full FIFO still takes a write when a read frees the slot in the same edge.
  always_comb begin
    live   = bus.en && !bus.clr;
    wr_acc = live && bus.wr && (!full_w || bus.rd);
    rd_acc = live && bus.rd && !empty_w;
    wr_rej = live && bus.wr && full_w && !bus.rd;
    rd_rej = live && bus.rd && empty_w;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else if (bus.clr) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
      if (wr_acc && !rd_acc)      count_q <= count_q + 1'b1;
      else if (rd_acc && !wr_acc) count_q <= count_q - 1'b1;
      if (wr_rej) ovf_q <= 1'b1;
      if (rd_rej) udf_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= bus.dataIn;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Zero while empty keeps the output deterministic; the head word is otherwise live.
      assign bus.dataOut = empty_w ? '0 : mem[rd_ptr];
    end else begin : g_std
      logic [DWIDTH-1:0] dout_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       dout_q <= '0;
        else if (bus.clr) dout_q <= '0;
        else if (rd_acc)  dout_q <= mem[rd_ptr];
      end
      assign bus.dataOut = dout_q;
    end
  endgenerate

  assign bus.full         = full_w;
  assign bus.empty        = empty_w;
  assign bus.almost_full  = (count_q >= AFULL_C);
  assign bus.almost_empty = (count_q <= AEMPTY_C);
  assign bus.count        = count_q;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = udf_q;
endmodule
